// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared sizing helpers for the pipelined right barrel shifter
//
// Purpose: derives the stage count and the width of one flattened stage
// record {valid, fill, data, shamt}. The stage_t struct itself is declared
// per instance (it depends on N), using stage_width() so every module agrees
// on the packed layout that travels between stages.
package shift_pkg;

  localparam int DEFAULT_N = 8;

  // Number of barrel stages: one per shift-amount bit. N = 1 is not a legal
  // configuration, but clamp to 1 so widths never collapse to zero.
  function automatic int shift_stages(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Packed width of one stage record: valid + fill + data + shamt.
  function automatic int stage_width(input int n);
    return 2 + n + shift_stages(n);
  endfunction

endpackage

// File: rtl/right_shift_stage.sv
// rtl/right_shift_stage.sv - one barrel stage: conditional right shift by 2^K plus its register
//
// Purpose: shifts the incoming data right by 2^K when shamt[K] is set, filling
// vacated MSBs with the carried fill bit, and registers the whole stage record.
// Ports:
//   clk        in   1    clock, posedge
//   rst        in   1    asynchronous active-low reset, clears the stage register
//   in_stage   in   SW   packed {valid, fill, data, shamt} from the previous stage
//   out_stage  out  SW   registered record for the next stage
module right_shift_stage
  import shift_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int K      = 0,
  parameter int STAGES = shift_stages(N),
  parameter int SW     = stage_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] in_stage,
  output logic [SW-1:0] out_stage
);

  localparam int SH = 1 << K;

  typedef struct packed {
    logic              valid;
    logic              fill;
    logic [N-1:0]      data;
    logic [STAGES-1:0] shamt;
  } stage_t;

  stage_t cur;
  stage_t nxt;
  stage_t q;

  assign cur = in_stage;

  // Data registers update on bubbles too; downstream ignores data while
  // valid is low, so gating them would only add enable logic.
  always_comb begin
    nxt = cur;
    if (cur.shamt[K]) begin
      nxt.data = {{SH{cur.fill}}, cur.data[N-1:SH]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

  assign out_stage = q;

endmodule

// File: rtl/barrel_right_shift_pipelined.sv
// rtl/barrel_right_shift_pipelined.sv - pipelined variable right shifter, logical or arithmetic
//
// Purpose: log2(N)-stage barrel shifter. Stage k shifts by 2^k when shamt[k]
// is set. One beat per clock, no backpressure, fixed latency of STAGES cycles.
// Ports:
//   clk         in   1       clock, posedge
//   rst         in   1       asynchronous active-low reset; drops all in-flight beats
//   up_valid    in   1       input beat present
//   up_data     in   N       operand
//   up_shamt    in   STAGES  shift amount 0 .. N-1
//   up_arith    in   1       1 = replicate up_data[N-1], 0 = zero fill
//   down_valid  out  1       result beat present
//   down_data   out  N       shifted result
module barrel_right_shift_pipelined
  import shift_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int STAGES = shift_stages(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  input  logic [N-1:0]      up_data,
  input  logic [STAGES-1:0] up_shamt,
  input  logic              up_arith,
  output logic              down_valid,
  output logic [N-1:0]      down_data
);

  localparam int SW = stage_width(N);

  typedef struct packed {
    logic              valid;
    logic              fill;
    logic [N-1:0]      data;
    logic [STAGES-1:0] shamt;
  } stage_t;

  // chain[k] is the input of stage k; chain[STAGES] is the last register.
  logic [SW-1:0] chain [0:STAGES];

  stage_t entry;
  stage_t tail;

  // The fill bit is resolved once at entry so later stages never need the
  // original sign bit, which has already been shifted away by then.
  always_comb begin
    entry       = '0;
    entry.valid = up_valid;
    entry.fill  = up_arith & up_data[N-1];
    entry.data  = up_data;
    entry.shamt = up_shamt;
  end

  assign chain[0] = entry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    right_shift_stage #(
      .N      (N),
      .K      (k),
      .STAGES (STAGES),
      .SW     (SW)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_stage  (chain[k]),
      .out_stage (chain[k+1])
    );
  end

  assign tail       = chain[STAGES];
  assign down_valid = tail.valid;
  assign down_data  = tail.data;

  // Fill and shamt are spent by the time a beat leaves the last stage.
  logic unused_tail;
  assign unused_tail = ^{tail.fill, tail.shamt};

endmodule

// File: tb/tb_barrel_right_shift_pipelined.sv
// tb/tb_barrel_right_shift_pipelined.sv - self-checking bench for barrel_right_shift_pipelined
module tb_barrel_right_shift_pipelined;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up_valid = 1'b0;
  logic [7:0] up_data = 8'h00;
  logic [2:0] up_shamt = 3'd0;
  logic       up_arith = 1'b0;
  logic       down_valid;
  logic [7:0] down_data;

  barrel_right_shift_pipelined #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_shamt   (up_shamt),
    .up_arith   (up_arith),
    .down_valid (down_valid),
    .down_data  (down_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic       ar;
    logic [7:0] e;
  } vec_t;

  vec_t       vecs [12];
  logic [7:0] sb [$];
  logic [2:0] vh;
  int         checks = 0;
  int         errors = 0;
  int         nvalid = 0;
  bit         mon_en = 1'b0;

  // Expected down_valid: up_valid delayed three clocks, cleared by reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) vh <= 3'b000;
    else      vh <= {vh[1:0], up_valid};
  end

  function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] s, input logic ar);
    logic signed [7:0] sa;
    sa = a;
    if (ar) return 8'(sa >>> s);
    return a >> s;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic ar, input logic [7:0] e);
    up_valid = 1'b1;
    up_data  = d;
    up_shamt = s;
    up_arith = ar;
    sb.push_back(e);
    @(posedge clk);
    #1;
    up_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    up_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 8'(sb.size()), 8'd0);
  endtask

  initial begin
    logic [7:0] a;
    logic [2:0] s;
    logic       ar;

    vecs[0]  = '{8'hB6, 3'd3, 1'b0, 8'h16};
    vecs[1]  = '{8'hB6, 3'd3, 1'b1, 8'hF6};
    vecs[2]  = '{8'h36, 3'd3, 1'b1, 8'h06};
    vecs[3]  = '{8'hA5, 3'd0, 1'b0, 8'hA5};
    vecs[4]  = '{8'hA5, 3'd0, 1'b1, 8'hA5};
    vecs[5]  = '{8'h80, 3'd7, 1'b0, 8'h01};
    vecs[6]  = '{8'h80, 3'd7, 1'b1, 8'hFF};
    vecs[7]  = '{8'h7F, 3'd7, 1'b1, 8'h00};
    vecs[8]  = '{8'hFF, 3'd1, 1'b0, 8'h7F};
    vecs[9]  = '{8'hFF, 3'd1, 1'b1, 8'hFF};
    vecs[10] = '{8'h81, 3'd4, 1'b1, 8'hF8};
    vecs[11] = '{8'h81, 3'd2, 1'b0, 8'h20};

    fork
      begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
      forever begin
        @(negedge clk);
        if (mon_en) begin
          check("valid_delay", 8'(down_valid), 8'(vh[2]));
          if (down_valid) begin
            nvalid++;
            if (sb.size() == 0) check("unexpected_beat", 8'd1, 8'd0);
            else                check("data", down_data, sb.pop_front());
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 8'(down_valid), 8'd0);
    check("reset_data", down_data, 8'h00);
    rst = 1'b1;
    mon_en = 1'b1;

    // Latency: first result exactly three cycles after acceptance
    send(8'hB6, 3'd3, 1'b0, 8'h16);
    @(posedge clk); #1;
    check("lat_early", 8'(down_valid), 8'd0);
    @(posedge clk); #1;
    check("lat_valid", 8'(down_valid), 8'd1);
    check("lat_data", down_data, 8'h16);
    drain();

    // Directed vector table, back-to-back
    foreach (vecs[i]) send(vecs[i].d, vecs[i].s, vecs[i].ar, vecs[i].e);
    drain();

    // Back-to-back random stream
    nvalid = 0;
    for (int i = 0; i < 64; i++) begin
      a  = 8'($urandom);
      s  = 3'($urandom);
      ar = 1'($urandom);
      send(a, s, ar, model(a, s, ar));
    end
    drain();
    check("stream_count", 8'(nvalid), 8'd64);

    // Sparse random stream
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      else begin
        a  = 8'($urandom);
        s  = 3'($urandom);
        ar = 1'($urandom);
        send(a, s, ar, model(a, s, ar));
      end
    end
    drain();

    // Reset mid-flight: two beats in the pipe, a third presented, reset hits
    send(8'h11, 3'd1, 1'b0, 8'h08);
    send(8'h22, 3'd1, 1'b0, 8'h11);
    up_valid = 1'b1;
    up_data  = 8'h33;
    rst      = 1'b0;
    #1;
    check("midrst_valid", 8'(down_valid), 8'd0);
    check("midrst_data", down_data, 8'h00);
    sb.delete();
    @(posedge clk); #1;
    up_valid = 1'b0;
    rst = 1'b1;
    nvalid = 0;
    idle(5);
    check("midrst_dropped", 8'(nvalid), 8'd0);

    send(8'hC3, 3'd1, 1'b1, 8'hE1);
    @(posedge clk); #1;
    check("post_rst_early", 8'(down_valid), 8'd0);
    @(posedge clk); #1;
    check("post_rst_valid", 8'(down_valid), 8'd1);
    check("post_rst_data", down_data, 8'hE1);
    drain();

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
